bcd_to_bin_seq: RTL and testbench

BCD_TO_BIN_SEQ -- requirements
Module: bcd_to_bin_seq

---
 rtl/bcd_to_bin_seq_if.sv | 31 +++
 rtl/bcd_to_bin_seq.sv | 122 ++++++++++++
 tb/tb_bcd_to_bin_seq.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/bcd_to_bin_seq_if.sv
// Request/result bundle for the sequential BCD-to-binary converter.
// Latency: n/a (wires only).  Backpressure: none; start is ignored while busy.
interface bcd_to_bin_seq_if #(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
) ();
    logic                  start;
    logic [4*DIGITS-1:0]   bcd_in;
    logic                  busy;
    logic                  done;
    logic [BIN_W-1:0]      bin_out;
    logic                  err;

    modport master (
        output start,
        output bcd_in,
        input  busy,
        input  done,
        input  bin_out,
        input  err
    );

    modport slave (
        input  start,
        input  bcd_in,
        output busy,
        output done,
        output bin_out,
        output err
    );
endinterface

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter (reverse double-dabble, one bit per cycle).
// Latency: done BIN_W+1 cycles after accept (1 cycle for an invalid digit).
// Backpressure: start only sampled in IDLE; requests while busy are dropped.
module bcd_to_bin_seq #(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
) (
    input  logic              clk,
    input  logic              rst,
    bcd_to_bin_seq_if.slave   bus
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [BCD_W-1:0]   bcd_sh, bcd_corr;
    logic [BIN_W-1:0]   sr_q, sr_d, sr_shift;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;
    logic               in_valid;
    logic               last_shift;

    always_comb begin
        in_valid = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (bus.bcd_in[4*i +: 4] > 4'd9) begin
                in_valid = 1'b0;
            end
        end
    end

    // Halving a digit that picked up 8 from its upper neighbour must give 5, so subtract 3.
    always_comb begin
        bcd_sh   = bcd_q >> 1;
        sr_shift = {bcd_q[0], sr_q[BIN_W-1:1]};
        bcd_corr = bcd_sh;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_sh[4*i +: 4] >= 4'd8) begin
                bcd_corr[4*i +: 4] = bcd_sh[4*i +: 4] - 4'd3;
            end
        end
    end

    assign last_shift = (cnt_q == CNT_W'(BIN_W - 1));

    always_comb begin
        state_d = state_q;
        bcd_d   = bcd_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        bin_d   = bin_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (in_valid) begin
                        bcd_d   = bus.bcd_in;
                        sr_d    = '0;
                        cnt_d   = '0;
                        state_d = CONV;
                    end else begin
                        bin_d   = '0;
                        err_d   = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            CONV: begin
                bcd_d = bcd_corr;
                sr_d  = sr_shift;
                cnt_d = cnt_q + CNT_W'(1);
                if (last_shift) begin
                    bin_d   = sr_shift;
                    err_d   = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            bcd_q   <= '0;
            sr_q    <= '0;
            cnt_q   <= '0;
            bin_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bcd_q   <= bcd_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            bin_q   <= bin_d;
            err_q   <= err_d;
        end
    end

    assign bus.busy    = (state_q != IDLE);
    assign bus.done    = (state_q == DONE);
    assign bus.bin_out = bin_q;
    assign bus.err     = err_q;

    // Every BCD bit must have been shifted out once the last shift completes.
    assert property (@(posedge clk) disable iff (rst)
        (state_q == CONV && last_shift) |-> (bcd_corr == '0));

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Directed bench for bcd_to_bin_seq: latency, invalid digits, ignored starts,
// async reset abort and an exhaustive 000..999 sweep against a decimal model.
module tb_bcd_to_bin_seq;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    bcd_to_bin_seq_if #(.DIGITS(3), .BIN_W(10)) bus ();

    bcd_to_bin_seq #(.DIGITS(3), .BIN_W(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] enc(input int v);
        enc = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // One request from IDLE; elat is the edge index (accept = 0) after which done is seen.
    task automatic run_conv(input string tag, input logic [11:0] bcd, input int eb,
                            input logic ee, input int elat);
        int lat;
        lat = -1;
        @(negedge clk);
        bus.start  = 1'b1;
        bus.bcd_in = bcd;
        @(negedge clk);
        bus.start  = 1'b0;
        bus.bcd_in = bcd ^ 12'h5A5;
        check({tag, "_busy"}, 32'(bus.busy), 32'd1);
        for (int k = 0; k <= 20 && lat < 0; k++) begin
            if (k > 0) @(negedge clk);
            if (bus.done) lat = k;
        end
        check({tag, "_lat"}, 32'(lat), 32'(elat));
        check({tag, "_bin"}, 32'(bus.bin_out), 32'(eb));
        check({tag, "_err"}, 32'(bus.err), 32'(ee));
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
        check({tag, "_idle"}, 32'(bus.busy), 32'd0);
        check({tag, "_hold"}, 32'(bus.bin_out), 32'(eb));
    endtask

    initial begin
        int dones;
        int idx;
        int cyc;
        int last;
        n_checks   = 0;
        n_fail     = 0;
        bus.start  = 1'b0;
        bus.bcd_in = '0;
        rst        = 1'b0;
        #1 rst     = 1'b1;
        #1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_bin", 32'(bus.bin_out), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_conv("c999", 12'h999, 999, 1'b0, 10);
        run_conv("c010", 12'h010, 10, 1'b0, 10);
        run_conv("c000", 12'h000, 0, 1'b0, 10);
        run_conv("c255", 12'h255, 255, 1'b0, 10);
        run_conv("c1a3", 12'h1A3, 0, 1'b1, 0);
        run_conv("c042", 12'h042, 42, 1'b0, 10);

        // Extra start pulses while converting must be dropped.
        @(negedge clk);
        bus.start  = 1'b1;
        bus.bcd_in = 12'h500;
        @(negedge clk);
        bus.start  = 1'b0;
        bus.bcd_in = 12'h111;
        dones = 0;
        for (int k = 0; k < 30; k++) begin
            if (k > 0) @(negedge clk);
            bus.start = (k == 2 || k == 8);
            if (bus.done) begin
                dones++;
                check("ign_bin", 32'(bus.bin_out), 32'd500);
                check("ign_lat", 32'(k), 32'd10);
            end
        end
        bus.start = 1'b0;
        check("ign_dones", 32'(dones), 32'd1);

        // Async reset in the middle of a conversion.
        @(negedge clk);
        bus.start  = 1'b1;
        bus.bcd_in = 12'h777;
        @(negedge clk);
        bus.start  = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_rst_busy", 32'(bus.busy), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("arst_busy", 32'(bus.busy), 32'd0);
        check("arst_done", 32'(bus.done), 32'd0);
        check("arst_bin", 32'(bus.bin_out), 32'd0);
        check("arst_err", 32'(bus.err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        check("arst_no_done", 32'(dones), 32'd0);
        run_conv("c123", 12'h123, 123, 1'b0, 10);

        // Exhaustive sweep with start held high: back-to-back every 12 cycles.
        idx  = 0;
        cyc  = 0;
        last = -1;
        @(negedge clk);
        bus.bcd_in = enc(0);
        bus.start  = 1'b1;
        while (idx < 1000 && cyc < 13000) begin
            @(negedge clk);
            cyc++;
            if (bus.done) begin
                check("exh_bin", 32'(bus.bin_out), 32'(idx));
                check("exh_err", 32'(bus.err), 32'd0);
                if (last >= 0) check("exh_gap", 32'(cyc - last), 32'd12);
                last = cyc;
                idx++;
                if (idx < 1000) bus.bcd_in = enc(idx);
                else bus.start = 1'b0;
            end
        end
        bus.start = 1'b0;
        check("exh_count", 32'(idx), 32'd1000);
        repeat (3) @(negedge clk);
        check("final_idle", 32'(bus.busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
